branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised, pipelined branch resolution unit for the RISC-V core.
- Takes two operands, funct3, PC, immediate and the front end's predicted direction.
- Computes equality and less-than (signed or unsigned, selected by funct3), the taken decision, branch target, redirect PC and mispredict flag.
- Sits between the execute operand muxes and the fetch redirect logic, with stall/flush control from the hazard unit.

Parameters:
- XLEN, 32, operand/PC/immediate width in bits (>= 8).
- STAGES, 1, pipeline depth: 1 or 2. Any other value is a synthesis error.
- CNT_WIDTH, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  branch instruction presented this cycle.
- in_funct3  in  3  branch funct3 field.
- in_rs1  in  XLEN  operand A.
- in_rs2  in  XLEN  operand B.
- in_pc  in  XLEN  PC of the branch.
- in_imm  in  XLEN  sign-extended B-type immediate.
- in_pred_taken  in  1  front-end prediction.
- stall  in  1  hold all stage registers.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  result valid.
- out_equal  out  1  rs1 == rs2.
- out_less_than  out  1  rs1 < rs2 (signedness from funct3).
- out_taken  out  1  branch taken.
- out_target  out  XLEN  pc + imm.
- out_redirect_pc  out  XLEN  taken ? target : pc + 4.
- out_mispredict  out  1  out_valid & (out_taken != pred_taken).
- out_illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Reset: all valid bits, and all outputs, are 0.
- Clock and reset: one clock domain; reset is synchronous and active-high, sampled only on the rising edge of clk.
- Decode:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT: taken = signed lt.
  - 101 BGE: taken = !signed lt.
  - 110 BLTU: taken = unsigned lt.
  - 111 BGEU: taken = !unsigned lt.
  - 010/011: illegal = 1, taken = 0.
  - out_less_than uses the unsigned compare when funct3[1] = 1, the signed compare otherwise.
- Arithmetic: target = pc + imm and fallthrough = pc + 4, both truncated modulo 2^XLEN (wrap-around, no overflow flag).
- STAGES = 1: compare, decode, adders and mispredict are all registered into one output stage. Latency is 1 cycle from the accepting edge.
- STAGES = 2:
  - Stage 1 registers eq, signed lt, unsigned lt, funct3, pc, imm and pred_taken.
  - Stage 2 registers the decision, target, redirect and mispredict.
  - Latency is 2 cycles; throughput is one branch per cycle.
- Acceptance: an input is accepted on an edge when in_valid = 1, stall = 0 and flush = 0.
- Stall (stall = 1, flush = 0): every stage register, valid bits included, holds its value. Outputs stay stable.
- Flush: clears every stage valid bit on the edge, and takes priority over stall and in_valid. Data registers may keep stale values; out_valid and out_mispredict must read 0 the following cycle.
- When out_valid = 0: out_mispredict, out_taken and out_illegal are forced to 0. out_equal, out_less_than and out_target are don't-care.
- Empty pipeline with in_valid = 0: valid bits advance as 0 (bubbles), no stall required.
- rst asserted mid-operation: identical to a flush, plus counters cleared.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- When defined, adds outputs perf_branches (CNT_WIDTH) and perf_mispredicts (CNT_WIDTH).
- Each counter increments on the edge where a valid entry is loaded into the final stage (counted once, regardless of later stall cycles). perf_mispredicts increments only when that entry's mispredict is 1.
- Both counters saturate at all-ones and are cleared by rst.
- When undefined, the ports and counter logic are absent; all other behaviour is unchanged.

Test Plan:
- STAGES=1, BLT, rs1=0xFFFFFFFF, rs2=0x00000001, pred=0, pc=0x100, imm=0x20 -> next cycle out_valid=1, lt=1, taken=1, target=0x120, redirect=0x120, mispredict=1.
- BLTU with the same operands, pred=1 -> taken=0, redirect=0x104, mispredict=1. BGEU with the same operands -> taken=1, mispredict=0.
- STAGES=2, back-to-back BEQ 5/5 then BNE 5/5 -> results on cycles 2 and 3: taken=1 then taken=0; out_valid high for 2 consecutive cycles.
- In-flight branch plus stall=1 for 3 cycles -> outputs frozen; then flush=1 with stall=1 -> out_valid=0 next cycle.
- funct3=010, pred=1 -> illegal=1, taken=0, mispredict=1. pc=0xFFFFFFFC, imm=8, BEQ equal -> target=0x00000004 (wrap).
- BRANCH_PERF_CNT_EN, CNT_WIDTH=4, 20 mispredicted branches -> perf_branches=perf_mispredicts=0xF (saturated). rst -> both 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: compare, decide, target/redirect, mispredict (1 or 2 stages).
// Optional perf counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic            out_equal,
    output logic            out_less_than,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_branches,
    output logic [CNT_WIDTH-1:0] perf_mispredicts
`endif
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("branch_resolve_unit: STAGES must be 1 or 2");
    end
    if (XLEN < 8 || CNT_WIDTH < 1) begin : g_bad_width
        $error("branch_resolve_unit: XLEN must be >= 8, CNT_WIDTH >= 1");
    end

    function automatic logic decide(
        input logic [2:0] f3,
        input logic       eq,
        input logic       slt,
        input logic       ult
    );
        logic t;
        t = 1'b0;
        unique case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = slt;
            3'b101:  t = !slt;
            3'b110:  t = ult;
            3'b111:  t = !ult;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Inputs to the final stage, sourced from the ports or from stage 1.
    logic            f_valid;
    logic            f_eq;
    logic            f_slt;
    logic            f_ult;
    logic            f_pred;
    logic [2:0]      f_funct3;
    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] f_imm;

    if (STAGES == 2) begin : g_two
        logic            s1_valid;
        logic            s1_eq;
        logic            s1_slt;
        logic            s1_ult;
        logic            s1_pred;
        logic [2:0]      s1_funct3;
        logic [XLEN-1:0] s1_pc;
        logic [XLEN-1:0] s1_imm;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid  <= 1'b0;
                s1_eq     <= 1'b0;
                s1_slt    <= 1'b0;
                s1_ult    <= 1'b0;
                s1_pred   <= 1'b0;
                s1_funct3 <= '0;
                s1_pc     <= '0;
                s1_imm    <= '0;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (!stall) begin
                s1_valid  <= in_valid;
                s1_eq     <= in_rs1 == in_rs2;
                s1_slt    <= $signed(in_rs1) < $signed(in_rs2);
                s1_ult    <= in_rs1 < in_rs2;
                s1_pred   <= in_pred_taken;
                s1_funct3 <= in_funct3;
                s1_pc     <= in_pc;
                s1_imm    <= in_imm;
            end
        end

        assign f_valid  = s1_valid;
        assign f_eq     = s1_eq;
        assign f_slt    = s1_slt;
        assign f_ult    = s1_ult;
        assign f_pred   = s1_pred;
        assign f_funct3 = s1_funct3;
        assign f_pc     = s1_pc;
        assign f_imm    = s1_imm;
    end else begin : g_one
        assign f_valid  = in_valid;
        assign f_eq     = in_rs1 == in_rs2;
        assign f_slt    = $signed(in_rs1) < $signed(in_rs2);
        assign f_ult    = in_rs1 < in_rs2;
        assign f_pred   = in_pred_taken;
        assign f_funct3 = in_funct3;
        assign f_pc     = in_pc;
        assign f_imm    = in_imm;
    end

    logic            f_taken;
    logic            f_illegal;
    logic            f_lt;
    logic            f_mis;
    logic [XLEN-1:0] f_target;
    logic [XLEN-1:0] f_redirect;

    assign f_taken    = decide(f_funct3, f_eq, f_slt, f_ult);
    assign f_illegal  = f_funct3[2:1] == 2'b01;
    assign f_lt       = f_funct3[1] ? f_ult : f_slt;
    assign f_target   = f_pc + f_imm;
    assign f_redirect = f_taken ? f_target : f_pc + XLEN'(4);
    assign f_mis      = f_taken != f_pred;

    logic            r_valid;
    logic            r_eq;
    logic            r_lt;
    logic            r_taken;
    logic            r_illegal;
    logic            r_mis;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b0;
            r_mis      <= 1'b0;
            r_target   <= '0;
            r_redirect <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid    <= f_valid;
            r_eq       <= f_eq;
            r_lt       <= f_lt;
            r_taken    <= f_taken;
            r_illegal  <= f_illegal;
            r_mis      <= f_mis;
            r_target   <= f_target;
            r_redirect <= f_redirect;
        end
    end

    // Status flags only mean something for a live entry.
    assign out_valid       = r_valid;
    assign out_equal       = r_eq;
    assign out_less_than   = r_lt;
    assign out_taken       = r_valid & r_taken;
    assign out_illegal     = r_valid & r_illegal;
    assign out_mispredict  = r_valid & r_mis;
    assign out_target      = r_target;
    assign out_redirect_pc = r_redirect;

`ifdef BRANCH_PERF_CNT_EN
    logic load_final;
    assign load_final = !flush && !stall && f_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (load_final) begin
            if (!(&perf_branches))
                perf_branches <= perf_branches + CNT_WIDTH'(1);
            if (f_mis && !(&perf_mispredicts))
                perf_mispredicts <= perf_mispredicts + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: 1- and 2-stage instances share one stimulus stream,
// each checked by its own expected-result queue plus directed spot checks.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        eq;
        logic        lt;
        logic        tk;
        logic        ill;
        logic [31:0] tgt;
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_imm = '0;
    logic        in_pred = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        o1_valid, o1_eq, o1_lt, o1_tk, o1_mis, o1_ill;
    logic [31:0] o1_tgt, o1_rd;
    logic        o2_valid, o2_eq, o2_lt, o2_tk, o2_mis, o2_ill;
    logic [31:0] o2_tgt, o2_rd;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] p1_br, p1_mis;
    logic [3:0]  p2_br, p2_mis;
`endif

    int   ncmp = 0;
    int   nerr = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t last1, last2, te;
    logic adv = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred), .stall(stall), .flush(flush),
        .out_valid(o1_valid), .out_equal(o1_eq), .out_less_than(o1_lt),
        .out_taken(o1_tk), .out_target(o1_tgt), .out_redirect_pc(o1_rd),
        .out_mispredict(o1_mis), .out_illegal(o1_ill)
`ifdef BRANCH_PERF_CNT_EN
        , .perf_branches(p1_br), .perf_mispredicts(p1_mis)
`endif
    );

    branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred), .stall(stall), .flush(flush),
        .out_valid(o2_valid), .out_equal(o2_eq), .out_less_than(o2_lt),
        .out_taken(o2_tk), .out_target(o2_tgt), .out_redirect_pc(o2_rd),
        .out_mispredict(o2_mis), .out_illegal(o2_ill)
`ifdef BRANCH_PERF_CNT_EN
        , .perf_branches(p2_br), .perf_mispredicts(p2_mis)
`endif
    );

    function automatic exp_t model(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic p);
        exp_t e;
        logic slt, ult;
        e.eq  = (a == b);
        slt   = $signed(a) < $signed(b);
        ult   = a < b;
        e.ill = 1'b0;
        case (f)
            3'b000:  e.tk = e.eq;
            3'b001:  e.tk = !e.eq;
            3'b100:  e.tk = slt;
            3'b101:  e.tk = !slt;
            3'b110:  e.tk = ult;
            3'b111:  e.tk = !ult;
            default: begin e.tk = 1'b0; e.ill = 1'b1; end
        endcase
        e.lt  = f[1] ? ult : slt;
        e.tgt = pc + imm;
        e.rd  = e.tk ? e.tgt : pc + 32'd4;
        e.mis = (e.tk != p);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic eq, input logic lt,
                       input logic tk, input logic ill, input logic [31:0] tgt,
                       input logic [31:0] rd, input logic mis);
        exp_t e;
        int   sz;
        string n;
        n = $sformatf("d%0d", id);
        if (v === 1'b1) begin
            if (adv) begin
                sz = (id == 1) ? q1.size() : q2.size();
                chk({n, "_expected_pending"}, 32'(sz > 0), 32'd1);
                if (sz == 0) return;
                if (id == 1) begin e = q1.pop_front(); last1 = e; end
                else begin e = q2.pop_front(); last2 = e; end
            end else begin
                e = (id == 1) ? last1 : last2;
            end
            chk({n, "_equal"}, 32'(eq), 32'(e.eq));
            chk({n, "_lt"}, 32'(lt), 32'(e.lt));
            chk({n, "_taken"}, 32'(tk), 32'(e.tk));
            chk({n, "_illegal"}, 32'(ill), 32'(e.ill));
            chk({n, "_target"}, tgt, e.tgt);
            chk({n, "_redirect"}, rd, e.rd);
            chk({n, "_mispredict"}, 32'(mis), 32'(e.mis));
        end else begin
            chk({n, "_valid_known"}, 32'(v), 32'd0);
            chk({n, "_idle_taken"}, 32'(tk), 32'd0);
            chk({n, "_idle_illegal"}, 32'(ill), 32'd0);
            chk({n, "_idle_mispredict"}, 32'(mis), 32'd0);
        end
    endtask

    // Scoreboard producer: entries enter on accepting edges, die on flush/reset.
    always @(posedge clk) begin
        if (rst || flush) begin
            q1.delete();
            q2.delete();
            adv = 1'b0;
        end else if (stall) begin
            adv = 1'b0;
        end else begin
            adv = 1'b1;
            if (in_valid) begin
                te = model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred);
                q1.push_back(te);
                q2.push_back(te);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, o1_valid, o1_eq, o1_lt, o1_tk, o1_ill, o1_tgt, o1_rd, o1_mis);
            mon(2, o2_valid, o2_eq, o2_lt, o2_tk, o2_ill, o2_tgt, o2_rd, o2_mis);
        end
    end

    task automatic go(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] imm, input logic p);
        in_valid  = v;
        in_funct3 = f;
        in_rs1    = a;
        in_rs2    = b;
        in_pc     = pc;
        in_imm    = imm;
        in_pred   = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        go(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_d1_valid", 32'(o1_valid), 32'd0);
        chk("rst_d2_valid", 32'(o2_valid), 32'd0);
        chk("rst_d1_target", o1_tgt, 32'd0);
        chk("rst_d1_redirect", o1_rd, 32'd0);
        chk("rst_d2_redirect", o2_rd, 32'd0);

        go(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        chk("blt_d1_valid", 32'(o1_valid), 32'd1);
        chk("blt_d1_lt", 32'(o1_lt), 32'd1);
        chk("blt_d1_taken", 32'(o1_tk), 32'd1);
        chk("blt_d1_target", o1_tgt, 32'h120);
        chk("blt_d1_redirect", o1_rd, 32'h120);
        chk("blt_d1_mispredict", 32'(o1_mis), 32'd1);
        chk("blt_d2_latency", 32'(o2_valid), 32'd0);

        go(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1);
        chk("bltu_d1_taken", 32'(o1_tk), 32'd0);
        chk("bltu_d1_redirect", o1_rd, 32'h104);
        chk("bltu_d1_mispredict", 32'(o1_mis), 32'd1);
        chk("blt_d2_valid", 32'(o2_valid), 32'd1);
        chk("blt_d2_taken", 32'(o2_tk), 32'd1);

        go(1'b1, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1);
        chk("bgeu_d1_taken", 32'(o1_tk), 32'd1);
        chk("bgeu_d1_mispredict", 32'(o1_mis), 32'd0);

        go(1'b1, 3'b000, 32'd5, 32'd5, 32'h400, 32'h10, 1'b0);
        go(1'b1, 3'b001, 32'd5, 32'd5, 32'h404, 32'h10, 1'b0);
        chk("beq_d2_valid", 32'(o2_valid), 32'd1);
        chk("beq_d2_taken", 32'(o2_tk), 32'd1);
        idle();
        chk("bne_d2_valid", 32'(o2_valid), 32'd1);
        chk("bne_d2_taken", 32'(o2_tk), 32'd0);
        idle();
        chk("b2b_d2_drained", 32'(o2_valid), 32'd0);

        go(1'b1, 3'b010, 32'd3, 32'd9, 32'h200, 32'h10, 1'b1);
        chk("ill_d1_illegal", 32'(o1_ill), 32'd1);
        chk("ill_d1_taken", 32'(o1_tk), 32'd0);
        chk("ill_d1_mispredict", 32'(o1_mis), 32'd1);
        go(1'b1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'd8, 1'b1);
        chk("wrap_d1_target", o1_tgt, 32'h4);
        chk("wrap_d1_redirect", o1_rd, 32'h4);
        idle();
        chk("wrap_d2_target", o2_tgt, 32'h4);
        idle();

        go(1'b1, 3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            go(1'b1, 3'b000, 32'd9, 32'd9, 32'h900, 32'h4, 1'b0);
            chk("stall_d1_valid", 32'(o1_valid), 32'd1);
            chk("stall_d1_target", o1_tgt, 32'h340);
            chk("stall_d2_valid", 32'(o2_valid), 32'd0);
        end
        flush = 1'b1;
        go(1'b1, 3'b000, 32'd9, 32'd9, 32'h900, 32'h4, 1'b0);
        flush = 1'b0;
        stall = 1'b0;
        chk("flush_d1_valid", 32'(o1_valid), 32'd0);
        chk("flush_d1_mispredict", 32'(o1_mis), 32'd0);
        chk("flush_d2_valid", 32'(o2_valid), 32'd0);
        idle();
        chk("flush_d2_killed", 32'(o2_valid), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 11) == 0);
            go(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b,
               $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        stall = 1'b0;
        flush = 1'b0;
        idle();
        idle();
        idle();
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

`ifdef BRANCH_PERF_CNT_EN
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++)
            go(1'b1, 3'b000, 32'd1, 32'd2, 32'h500, 32'h8, 1'b1);
        idle();
        idle();
        chk("perf_branches_sat", 32'(p2_br), 32'hF);
        chk("perf_mispredicts_sat", 32'(p2_mis), 32'hF);
        chk("perf_d1_branches", p1_br, 32'd20);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("perf_branches_rst", 32'(p2_br), 32'd0);
        chk("perf_mispredicts_rst", 32'(p2_mis), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
